// File: rtl/fetch_stage.sv
// fetch_fifo: small circular buffer with synchronous clear, head visible combinationally.
// Latency: a push is visible at the head the cycle after it is written; pop frees the slot the same edge.
// Backpressure: out_vld/out_rdy handshake on the read side; writer must never push when count == DEPTH.
module fetch_fifo #(
    parameter int WIDTH = 41,
    parameter int DEPTH = 2
) (
    input  logic             core_clk,
    input  logic             arst_n,
    input  logic             clr,
    input  logic             in_vld,
    input  logic [WIDTH-1:0] in_dat,
    input  logic             out_rdy,
    output logic             out_vld,
    output logic [WIDTH-1:0] out_dat,
    output logic [2:0]       count
);
    // Storage is sized for the largest legal DEPTH so 2-bit pointers index it cleanly;
    // slots at or above DEPTH are never written.
    localparam logic [1:0] LAST = 2'(DEPTH - 1);

    logic [WIDTH-1:0] mem_q [4];
    logic [WIDTH-1:0] mem_d [4];
    logic [1:0]       wr_ptr_q, wr_ptr_d;
    logic [1:0]       rd_ptr_q, rd_ptr_d;
    logic [2:0]       count_q, count_d;
    logic             pop;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == LAST) ? 2'd0 : p + 2'd1;
    endfunction

    assign out_vld = (count_q != 3'd0);
    assign out_dat = mem_q[rd_ptr_q];
    assign count   = count_q;
    assign pop     = out_vld & out_rdy;

    // Next-state: clear wins over push/pop; otherwise write at tail, advance head on pop.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clr) begin
            wr_ptr_d = 2'd0;
            rd_ptr_d = 2'd0;
            count_d  = 3'd0;
        end else begin
            if (in_vld) begin
                mem_d[wr_ptr_q] = in_dat;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            count_d = count_q + {2'b00, in_vld} - {2'b00, pop};
        end
    end

    // State registers; storage is zeroed so the head reads 0 while in reset.
    always_ff @(posedge core_clk or negedge arst_n) begin
        if (!arst_n) begin
            for (int i = 0; i < 4; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            count_q  <= 3'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
endmodule

// fetch_stage: PC sequencing, single-cycle imem access and a DEPTH-entry buffer feeding decode.
// Latency: a word requested in cycle N reaches id_* no earlier than N+2; one instruction/cycle sustained.
// Backpressure: id_ready low fills the buffer; imem_req stops once buffered + in-flight would reach DEPTH.
module fetch_stage #(
    parameter int ADDR_W = 9,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              id_ready,
    output logic              id_valid,
    output logic [31:0]       id_instr,
    output logic [ADDR_W-1:0] id_pc,
    output logic [15:0]       fetch_cnt
);
    localparam int         EW      = 32 + ADDR_W;
    localparam logic [3:0] DEPTH_L = 4'(DEPTH);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              inflight_q, inflight_d;
    logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
    logic [15:0]       fetch_cnt_q, fetch_cnt_d;

    logic [2:0]        buf_cnt;
    logic [3:0]        occupancy;
    logic              pop;
    logic              push;
    logic [EW-1:0]     head_dat;

    // Buffer entries are {instr, pc}; a redirect flushes it in the same edge.
    fetch_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_ibuf (
        .core_clk (clk),
        .arst_n   (rst),
        .clr      (redirect_valid),
        .in_vld   (push),
        .in_dat   ({imem_rdata, inflight_pc_q}),
        .out_rdy  (id_ready),
        .out_vld  (id_valid),
        .out_dat  (head_dat),
        .count    (buf_cnt)
    );

    assign pop  = id_valid & id_ready;
    // The response of last cycle's request is dropped when a redirect arrives with it.
    assign push = inflight_q & ~redirect_valid;

    // Slots already promised (buffered + in flight) after this cycle's pop; a new request
    // is only safe when it still leaves room for its response.
    assign occupancy = {1'b0, buf_cnt} + {3'b000, inflight_q} - {3'b000, pop};

    // rst gates the request directly: all flops read zero in reset, which would otherwise
    // look like an empty pipe asking for address 0.
    assign imem_req  = rst & ~redirect_valid & (occupancy < DEPTH_L);
    assign imem_addr = pc_q;
    assign id_instr  = head_dat[EW-1:ADDR_W];
    assign id_pc     = head_dat[ADDR_W-1:0];
    assign fetch_cnt = fetch_cnt_q;

    // Next PC, in-flight tracking and the saturating delivered-instruction counter.
    always_comb begin
        pc_d          = pc_q;
        inflight_d    = imem_req;
        inflight_pc_d = pc_q;
        fetch_cnt_d   = fetch_cnt_q;
        if (redirect_valid) begin
            pc_d = redirect_pc;
        end else if (imem_req) begin
            pc_d = pc_q + ADDR_W'(1);
        end
        if (pop && (fetch_cnt_q != 16'hFFFF)) begin
            fetch_cnt_d = fetch_cnt_q + 16'd1;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q          <= '0;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            fetch_cnt_q   <= 16'd0;
        end else begin
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            fetch_cnt_q   <= fetch_cnt_d;
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed scenarios plus randomized ready/redirect traffic against a queue model.
// The model tracks issued fetches in program order with their issue cycle.
// Memory is an array answering one cycle after each request; idle cycles return random junk.
module tb_fetch_stage;
    localparam int ADDR_W = 9;
    localparam int DEPTH  = 2;
    localparam int NPC    = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_rdata = 32'd0;
    logic              redirect_valid = 1'b0;
    logic [ADDR_W-1:0] redirect_pc = '0;
    logic              id_ready = 1'b0;
    logic              id_valid;
    logic [31:0]       id_instr;
    logic [ADDR_W-1:0] id_pc;
    logic [15:0]       fetch_cnt;

    always #5 clk = ~clk;

    fetch_stage #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_ready       (id_ready),
        .id_valid       (id_valid),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .fetch_cnt      (fetch_cnt)
    );

    logic [31:0] mem [NPC];
    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Instruction memory: latch the request mid-cycle, answer on the next edge.
    logic              req_s  = 1'b0;
    logic [ADDR_W-1:0] addr_s = '0;
    always @(negedge clk) begin
        req_s  = imem_req;
        addr_s = imem_addr;
    end
    always @(posedge clk) begin
        imem_rdata <= req_s ? mem[addr_s] : $urandom;
    end

    // Reference model: queue of fetches issued since the last flush, in program order.
    typedef struct packed { int pc; int cyc; } ent_t;
    ent_t q[$];
    int   fetch_pc  = 0;
    int   delivered = 0;
    int   cyc       = 0;
    bit   ev, ep, er;

    always @(negedge clk) begin
        if (!rst) begin
            q.delete();
            fetch_pc  = 0;
            delivered = 0;
            cyc       = 0;
        end else begin
            ev = 1'b0;
            if (q.size() > 0) begin
                if (q[0].cyc <= cyc - 2) ev = 1'b1;
            end
            chk("m_id_valid", 32'(id_valid), 32'(ev));
            if (ev) begin
                chk("m_id_pc", 32'(id_pc), 32'(q[0].pc));
                chk("m_id_instr", id_instr, mem[q[0].pc]);
            end
            chk("m_fetch_cnt", 32'(fetch_cnt), 32'(delivered));
            ep = ev && id_ready;
            er = !redirect_valid && ((q.size() - int'(ep)) < DEPTH);
            chk("m_imem_req", 32'(imem_req), 32'(er));
            if (er) chk("m_imem_addr", 32'(imem_addr), 32'(fetch_pc));
            if (ep) begin
                void'(q.pop_front());
                delivered++;
            end
            if (redirect_valid) begin
                q.delete();
                fetch_pc = int'(redirect_pc);
            end else if (er) begin
                q.push_back('{pc: fetch_pc, cyc: cyc});
                fetch_pc = (fetch_pc + 1) % NPC;
            end
            cyc++;
        end
    end

    logic [31:0]       words [4];
    logic [ADDR_W-1:0] hold_pc;
    logic [31:0]       hold_instr;
    int                d0;
    bit                got;

    task automatic wait_valid(output bit seen);
        seen = 1'b0;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            if (id_valid) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        words[0] = 32'h40400000;
        words[1] = 32'h00000000;
        words[2] = 32'h00000000;
        words[3] = 32'h8A000000;
        for (int i = 0; i < NPC; i++) begin
            mem[i] = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
        end
        for (int i = 0; i < 4; i++) mem[i] = words[i];
        id_ready = 1'b1;

        // Reset state
        #12;
        chk("rst_req",   32'(imem_req),  32'd0);
        chk("rst_addr",  32'(imem_addr), 32'd0);
        chk("rst_valid", 32'(id_valid),  32'd0);
        chk("rst_instr", id_instr,       32'd0);
        chk("rst_pc",    32'(id_pc),     32'd0);
        chk("rst_cnt",   32'(fetch_cnt), 32'd0);
        @(posedge clk); #1 rst = 1'b1;

        // First fetches: fill latency and in-order delivery of words 0..3
        @(negedge clk);
        chk("first_req",  32'(imem_req),  32'd1);
        chk("first_addr", 32'(imem_addr), 32'd0);
        chk("fill0",      32'(id_valid),  32'd0);
        @(negedge clk);
        chk("fill1",      32'(id_valid),  32'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("seq_valid", 32'(id_valid), 32'd1);
            chk("seq_pc",    32'(id_pc),    32'(k));
            chk("seq_instr", id_instr,      words[k]);
        end
        @(negedge clk);
        chk("cnt4", 32'(fetch_cnt), 32'd4);

        // Five-cycle decode stall: head holds, requests stop
        @(posedge clk); #1 id_ready = 1'b0;
        @(negedge clk);
        hold_pc    = id_pc;
        hold_instr = id_instr;
        for (int s = 0; s < 4; s++) begin
            @(negedge clk);
            chk("stall_valid", 32'(id_valid), 32'd1);
            chk("stall_pc",    32'(id_pc),    32'(hold_pc));
            chk("stall_instr", id_instr,      hold_instr);
        end
        chk("stall_req", 32'(imem_req), 32'd0);
        @(posedge clk); #1 id_ready = 1'b1;
        repeat (4) @(negedge clk);

        // Redirect to 3 while the buffer holds a word and a fetch is in flight
        @(posedge clk); #1 id_ready = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk); #1 id_ready = 1'b1;
        @(posedge clk); #1 id_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = ADDR_W'(3);
        @(negedge clk);
        chk("r3_req", 32'(imem_req), 32'd0);
        @(posedge clk); #1 redirect_valid = 1'b0; id_ready = 1'b1;
        wait_valid(got);
        chk("r3_seen",  32'(got),   32'd1);
        chk("r3_pc",    32'(id_pc), 32'd3);
        chk("r3_instr", id_instr,   32'h8A000000);
        repeat (3) @(negedge clk);

        // Redirect coinciding with a pop
        @(posedge clk); #1 redirect_valid = 1'b1; redirect_pc = ADDR_W'(100);
        d0 = delivered;
        chk("rp_pre_valid", 32'(id_valid), 32'd1);
        @(posedge clk); #1 redirect_valid = 1'b0;
        chk("rp_empty", 32'(id_valid),  32'd0);
        chk("rp_cnt",   32'(fetch_cnt), 32'(d0 + 1));
        repeat (4) @(negedge clk);

        // Redirect to the top address: PC wraps
        @(posedge clk); #1 redirect_valid = 1'b1; redirect_pc = ADDR_W'(NPC - 1);
        @(posedge clk); #1 redirect_valid = 1'b0;
        wait_valid(got);
        chk("wrap_seen", 32'(got),   32'd1);
        chk("wrap_pc0",  32'(id_pc), 32'(NPC - 1));
        @(negedge clk);
        chk("wrap_pc1",  32'(id_pc), 32'd0);
        @(negedge clk);
        chk("wrap_pc2",  32'(id_pc), 32'd1);
        repeat (3) @(negedge clk);

        // Asynchronous reset mid-stream
        @(posedge clk); #3 rst = 1'b0;
        #1;
        chk("arst_req",   32'(imem_req),  32'd0);
        chk("arst_addr",  32'(imem_addr), 32'd0);
        chk("arst_valid", 32'(id_valid),  32'd0);
        chk("arst_instr", id_instr,       32'd0);
        chk("arst_pc",    32'(id_pc),     32'd0);
        chk("arst_cnt",   32'(fetch_cnt), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("rel_req",  32'(imem_req),  32'd1);
        chk("rel_addr", 32'(imem_addr), 32'd0);
        wait_valid(got);
        chk("rel_seen", 32'(got),   32'd1);
        chk("rel_pc",   32'(id_pc), 32'd0);

        // Randomized ready and redirect traffic
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            id_ready       = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 15) == 0);
            redirect_pc    = ADDR_W'($urandom);
        end
        @(posedge clk); #1 redirect_valid = 1'b0; id_ready = 1'b1;
        repeat (6) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
        $fatal(1);
    end
endmodule
